// File: rtl/mmc_chan_cmd_seq_if.sv
// Request/DFI bundle for one MMC channel command sequencer.
//   init_done                        DFI init complete
//   req_valid/req_ready              request handshake
//   req_write/req_bank/page/line     request payload
//   dfi_cs/dfi_cmd1/dfi_cmd0         command strobe and {cmd1,cmd0} encoding
//   dfi_bank/dfi_addr                command bank and address
// Modports: slave = sequencer side, master = requester/DFI model side.
interface mmc_chan_cmd_seq_if #(
   parameter int NUM_BANKS = 32,
   parameter int PAGE_W    = 12,
   parameter int LINE_W    = 6,
   parameter int ADDR_W    = 15
);
   localparam int BANK_W = $clog2(NUM_BANKS);

   logic              init_done;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [BANK_W-1:0] req_bank;
   logic [PAGE_W-1:0] req_page;
   logic [LINE_W-1:0] req_line;
   logic              dfi_cs;
   logic              dfi_cmd1;
   logic              dfi_cmd0;
   logic [BANK_W-1:0] dfi_bank;
   logic [ADDR_W-1:0] dfi_addr;

   modport slave (
      input  init_done, req_valid, req_write, req_bank, req_page, req_line,
      output req_ready, dfi_cs, dfi_cmd1, dfi_cmd0, dfi_bank, dfi_addr
   );

   modport master (
      output init_done, req_valid, req_write, req_bank, req_page, req_line,
      input  req_ready, dfi_cs, dfi_cmd1, dfi_cmd0, dfi_bank, dfi_addr
   );
endinterface

// File: rtl/mmc_chan_cmd_seq.sv
// Per-channel DRAM command sequencer. Takes one read/write line request at a
// time, consults an open-page table and issues ACT/RD/WR/PRE to DFI while
// honouring tRCD (ACT->CAS), tRP (PRE->ACT) and tCCD (CAS->CAS).
// Ports:
//   clk            clock
//   reset_poweron  asynchronous reset, active high
//   bus            mmc_chan_cmd_seq_if.slave (request handshake + DFI command)
// Optional feature macro: MMC_CMD_SEQ_CLOSED_PAGE_EN
//   defined   -> closed-page: every CAS is followed by a PRE to the same bank
//                T_CCD cycles later, then a tRP wait before accepting again.
//   undefined -> open-page: banks stay open until a page conflict.
// All outputs are registered; cs is a single-cycle pulse per command.
module mmc_chan_cmd_seq #(
   parameter int NUM_BANKS = 32,
   parameter int PAGE_W    = 12,
   parameter int LINE_W    = 6,
   parameter int ADDR_W    = 15,
   parameter int T_RCD     = 3,
   parameter int T_RP      = 3,
   parameter int T_CCD     = 4
) (
   input  logic                  clk,
   input  logic                  reset_poweron,
   mmc_chan_cmd_seq_if.slave     bus
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int T_MAX  = (T_RCD > T_RP) ? ((T_RCD > T_CCD) ? T_RCD : T_CCD)
                                          : ((T_RP  > T_CCD) ? T_RP  : T_CCD);
   localparam int TMR_W  = $clog2(T_MAX + 1);

   localparam logic [1:0] C_ACT = 2'b00;
   localparam logic [1:0] C_RD  = 2'b01;
   localparam logic [1:0] C_WR  = 2'b10;
   localparam logic [1:0] C_PRE = 2'b11;

   typedef enum logic [2:0] {
      S_WAIT_INIT, S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_CAS, S_PRECHG
   } state_t;

   state_t                              state;
   logic [TMR_W-1:0]                    tmr;     // tRCD / tRP countdown
   logic [TMR_W-1:0]                    ccd;     // tCCD countdown, 0 = expired
   logic                                r_write;
   logic [BANK_W-1:0]                   r_bank;
   logic [PAGE_W-1:0]                   r_page;
   logic [LINE_W-1:0]                   r_line;
   logic [NUM_BANKS-1:0]                open_q;
   logic [NUM_BANKS-1:0][PAGE_W-1:0]    page_q;
   logic                                ready_q;
   logic                                cs_q;
   logic [1:0]                          cmd_q;
   logic [BANK_W-1:0]                   bank_q;
   logic [ADDR_W-1:0]                   addr_q;

   assign bus.req_ready = ready_q;
   assign bus.dfi_cs    = cs_q;
   assign bus.dfi_cmd1  = cmd_q[1];
   assign bus.dfi_cmd0  = cmd_q[0];
   assign bus.dfi_bank  = bank_q;
   assign bus.dfi_addr  = addr_q;

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         state   <= S_WAIT_INIT;
         tmr     <= '0;
         ccd     <= '0;
         r_write <= 1'b0;
         r_bank  <= '0;
         r_page  <= '0;
         r_line  <= '0;
         open_q  <= '0;
         page_q  <= '0;
         ready_q <= 1'b0;
         cs_q    <= 1'b0;
         cmd_q   <= 2'b00;
         bank_q  <= '0;
         addr_q  <= '0;
      end else begin
         // command outputs default to idle; a command state overrides for one cycle
         cs_q   <= 1'b0;
         cmd_q  <= 2'b00;
         bank_q <= '0;
         addr_q <= '0;
         // tCCD runs everywhere; a CAS issue below reloads it
         if (ccd != '0) ccd <= ccd - TMR_W'(1);

         case (state)
            S_WAIT_INIT: begin
               if (bus.init_done) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end

            S_IDLE: begin
               if (bus.req_valid) begin
                  ready_q <= 1'b0;
                  r_write <= bus.req_write;
                  r_bank  <= bus.req_bank;
                  r_page  <= bus.req_page;
                  r_line  <= bus.req_line;
                  if (!open_q[bus.req_bank])
                     state <= S_ACT;
                  else if (page_q[bus.req_bank] == bus.req_page)
                     state <= S_CAS;
                  else
                     state <= S_PRE;
               end
            end

            S_PRE: begin
               cs_q           <= 1'b1;
               cmd_q          <= C_PRE;
               bank_q         <= r_bank;
               open_q[r_bank] <= 1'b0;
               if (T_RP == 1) begin
                  state <= S_ACT;
               end else begin
                  tmr   <= TMR_W'(T_RP - 1);
                  state <= S_PRE_WAIT;
               end
            end

            // Exits on the cycle the count reads 1 so the next command lands
            // exactly T_RP after the PRE.
            S_PRE_WAIT: begin
               if (tmr <= TMR_W'(1)) begin
`ifdef MMC_CMD_SEQ_CLOSED_PAGE_EN
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
`else
                  state   <= S_ACT;
`endif
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end

            S_ACT: begin
               cs_q           <= 1'b1;
               cmd_q          <= C_ACT;
               bank_q         <= r_bank;
               addr_q         <= ADDR_W'(r_page);
               open_q[r_bank] <= 1'b1;
               page_q[r_bank] <= r_page;
               if (T_RCD == 1) begin
                  state <= S_CAS;
               end else begin
                  tmr   <= TMR_W'(T_RCD - 1);
                  state <= S_ACT_WAIT;
               end
            end

            S_ACT_WAIT: begin
               if (tmr <= TMR_W'(1)) state <= S_CAS;
               else                  tmr   <= tmr - TMR_W'(1);
            end

            S_CAS: begin
               if (ccd == '0) begin
                  cs_q   <= 1'b1;
                  cmd_q  <= r_write ? C_WR : C_RD;
                  bank_q <= r_bank;
                  addr_q <= ADDR_W'(r_line);
                  ccd    <= TMR_W'(T_CCD - 1);
`ifdef MMC_CMD_SEQ_CLOSED_PAGE_EN
                  state   <= S_PRECHG;
`else
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
`endif
               end
            end

`ifdef MMC_CMD_SEQ_CLOSED_PAGE_EN
            // Auto-precharge waits on the same tCCD timer, so PRE lands
            // exactly T_CCD after the CAS.
            S_PRECHG: begin
               if (ccd == '0) begin
                  cs_q           <= 1'b1;
                  cmd_q          <= C_PRE;
                  bank_q         <= r_bank;
                  open_q[r_bank] <= 1'b0;
                  if (T_RP == 1) begin
                     state   <= S_IDLE;
                     ready_q <= 1'b1;
                  end else begin
                     tmr   <= TMR_W'(T_RP - 1);
                     state <= S_PRE_WAIT;
                  end
               end
            end
`endif

            default: begin
               state   <= S_WAIT_INIT;
               ready_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
